// File: rtl/banked_memory.sv
// Byte-addressable DEPTH_WORDS x 32 memory with an independent fetch port, a
// load port with sub-word extraction/extension, and a lane-masked store port.
module banked_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned OUT_REG     = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_enable,
  input  logic [31:0] pc,
  output logic [31:0] pc_value,
  output logic        pc_valid,
  output logic        pc_fault,
  input  logic        read_enable,
  input  logic [31:0] read_address,
  input  logic [1:0]  read_size,
  input  logic        read_unsigned,
  output logic [31:0] read_value,
  output logic        read_valid,
  output logic        read_fault,
  input  logic        write_enable,
  input  logic [31:0] write_address,
  input  logic [1:0]  write_size,
  input  logic [31:0] write_value,
  output logic        write_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_pc_idx, w_rd_idx, w_wr_idx;
  logic          w_pc_fault, w_rd_fault, w_wr_fault;
  logic [31:0]   w_rd_word, w_rd_ext, w_wr_data;
  logic [7:0]    w_rd_byte;
  logic [15:0]   w_rd_half;
  logic [3:0]    w_wr_be;

  logic          r_pc_valid, r_pc_fault, r_rd_valid, r_rd_fault, r_write_fault;
  logic [31:0]   r_pc_value, r_rd_value;

  function automatic logic f_out_of_range(input logic [31:0] a);
    return (a >> (AW + 2)) != 32'd0;
  endfunction

  function automatic logic f_misaligned(input logic [31:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  assign w_pc_idx   = pc[AW+1:2];
  assign w_rd_idx   = read_address[AW+1:2];
  assign w_wr_idx   = write_address[AW+1:2];
  assign w_pc_fault = f_out_of_range(pc) | f_misaligned(pc, 2'b10);
  assign w_rd_fault = f_out_of_range(read_address) | f_misaligned(read_address, read_size);
  assign w_wr_fault = f_out_of_range(write_address) | f_misaligned(write_address, write_size);

  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    w_rd_byte = w_rd_word[{read_address[1:0], 3'b000} +: 8];
    w_rd_half = w_rd_word[{read_address[1], 4'b0000} +: 16];
    case (read_size)
      2'b00:   w_rd_ext = {{24{~read_unsigned & w_rd_byte[7]}}, w_rd_byte};
      2'b01:   w_rd_ext = {{16{~read_unsigned & w_rd_half[15]}}, w_rd_half};
      default: w_rd_ext = w_rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target lanes.
  always_comb begin
    w_wr_be   = 4'b0000;
    w_wr_data = write_value;
    case (write_size)
      2'b00: begin
        w_wr_be   = 4'b0001 << write_address[1:0];
        w_wr_data = {4{write_value[7:0]}};
      end
      2'b01: begin
        w_wr_be   = write_address[1] ? 4'b1100 : 4'b0011;
        w_wr_data = {2{write_value[15:0]}};
      end
      2'b10:   w_wr_be = 4'b1111;
      default: w_wr_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (write_enable && !reset && !w_wr_fault) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_wr_be[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc_valid    <= 1'b0;
      r_pc_fault    <= 1'b0;
      r_pc_value    <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_fault    <= 1'b0;
      r_rd_value    <= '0;
      r_write_fault <= 1'b0;
    end else begin
      r_pc_valid    <= pc_enable;
      r_pc_fault    <= pc_enable & w_pc_fault;
      r_rd_valid    <= read_enable;
      r_rd_fault    <= read_enable & w_rd_fault;
      r_write_fault <= write_enable & w_wr_fault;
      if (pc_enable)   r_pc_value <= w_pc_fault ? '0 : r_mem[w_pc_idx];
      if (read_enable) r_rd_value <= w_rd_fault ? '0 : w_rd_ext;
    end
  end

  assign write_fault = r_write_fault;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic        r_pc_valid_q, r_pc_fault_q, r_rd_valid_q, r_rd_fault_q;
      logic [31:0] r_pc_value_q, r_rd_value_q;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_pc_valid_q <= 1'b0;
          r_pc_fault_q <= 1'b0;
          r_pc_value_q <= '0;
          r_rd_valid_q <= 1'b0;
          r_rd_fault_q <= 1'b0;
          r_rd_value_q <= '0;
        end else begin
          r_pc_valid_q <= r_pc_valid;
          r_pc_fault_q <= r_pc_fault;
          r_rd_valid_q <= r_rd_valid;
          r_rd_fault_q <= r_rd_fault;
          if (r_pc_valid) r_pc_value_q <= r_pc_value;
          if (r_rd_valid) r_rd_value_q <= r_rd_value;
        end
      end

      assign pc_valid   = r_pc_valid_q;
      assign pc_fault   = r_pc_fault_q;
      assign pc_value   = r_pc_value_q;
      assign read_valid = r_rd_valid_q;
      assign read_fault = r_rd_fault_q;
      assign read_value = r_rd_value_q;
    end else begin : g_no_out_reg
      assign pc_valid   = r_pc_valid;
      assign pc_fault   = r_pc_fault;
      assign pc_value   = r_pc_value;
      assign read_valid = r_rd_valid;
      assign read_fault = r_rd_fault;
      assign read_value = r_rd_value;
    end
  endgenerate

endmodule
